// File: rtl/fetch_pc_unit.sv
// fetch_pc_unit
//
// Fetch-stage program-counter controller. Owns the PC register, advances it by
// 4 on every unstalled cycle and applies redirects coming from the decode-stage
// jump logic. A redirect that shows up while fetch is stalled is parked in a
// pending register so it is applied as soon as the stall releases.
//
// Parameters
//   RESET_PC      PC value loaded by reset.
//   DELAY_SLOT    1: instruction fetched alongside a redirect is kept.
//                 0: that instruction is squashed (flush_d / fetch_valid).
//
// Ports
//   clock             rising-edge clock
//   reset_n           asynchronous, active-low reset
//   stall_f           hazard unit holds fetch; PC does not advance
//   pc_src            decode requests a redirect this cycle
//   jump_address      redirect target, valid with pc_src
//   pc                current fetch address (registered)
//   pc_plus_four      pc + 4, combinational, wraps modulo 2^32
//   fetch_valid       IF/ID should capture the instruction at pc
//   flush_d           clear IF/ID this cycle (only when DELAY_SLOT == 0)
//   redirect_pending  a stalled redirect is waiting
//   addr_error        one-cycle pulse after a misaligned redirect is captured
//   error_address     raw target of the most recent misaligned redirect

module fetch_pc_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0040_0000,
  parameter int          DELAY_SLOT = 1
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        stall_f,
  input  logic        pc_src,
  input  logic [31:0] jump_address,
  output logic [31:0] pc,
  output logic [31:0] pc_plus_four,
  output logic        fetch_valid,
  output logic        flush_d,
  output logic        redirect_pending,
  output logic        addr_error,
  output logic [31:0] error_address
);

  localparam logic SQUASH_SLOT = (DELAY_SLOT == 0);

  logic [31:0] pc_q, pc_d;
  logic        pend_valid_q, pend_valid_d;
  logic [31:0] pend_addr_q, pend_addr_d;
  logic        addr_error_q, addr_error_d;
  logic [31:0] error_address_q, error_address_d;

  logic [31:0] aligned_target;
  logic        target_misaligned;
  logic        taken;

  // Targets are always forced to word alignment; misalignment is only reported.
  assign aligned_target    = {jump_address[31:2], 2'b00};
  assign target_misaligned = (jump_address[1:0] != 2'b00);

  assign pc_plus_four = pc_q + 32'd4;

  // A live or pending redirect lands on pc at the next edge.
  assign taken = !stall_f && (pc_src || pend_valid_q);

  // Next-state logic. A live redirect always supersedes a pending one, and
  // while stalled the latest redirect overwrites whatever is parked.
  always_comb begin
    pc_d            = pc_q;
    pend_valid_d    = pend_valid_q;
    pend_addr_d     = pend_addr_q;
    addr_error_d    = 1'b0;
    error_address_d = error_address_q;

    if (!stall_f) begin
      if (pc_src) begin
        pc_d         = aligned_target;
        pend_valid_d = 1'b0;
      end else if (pend_valid_q) begin
        pc_d         = pend_addr_q;
        pend_valid_d = 1'b0;
      end else begin
        pc_d = pc_plus_four;
      end
    end else if (pc_src) begin
      pend_valid_d = 1'b1;
      pend_addr_d  = aligned_target;
    end

    // Every pc_src is captured: applied when unstalled, pended when stalled.
    if (pc_src && target_misaligned) begin
      addr_error_d    = 1'b1;
      error_address_d = jump_address;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pc_q            <= RESET_PC;
      pend_valid_q    <= 1'b0;
      pend_addr_q     <= 32'd0;
      addr_error_q    <= 1'b0;
      error_address_q <= 32'd0;
    end else begin
      pc_q            <= pc_d;
      pend_valid_q    <= pend_valid_d;
      pend_addr_q     <= pend_addr_d;
      addr_error_q    <= addr_error_d;
      error_address_q <= error_address_d;
    end
  end

  // Without a delay slot the instruction fetched in a redirect cycle is dead.
  assign fetch_valid      = !stall_f && !(SQUASH_SLOT && taken);
  assign flush_d          = SQUASH_SLOT && taken;
  assign pc               = pc_q;
  assign redirect_pending = pend_valid_q;
  assign addr_error       = addr_error_q;
  assign error_address    = error_address_q;

endmodule

// File: tb/tb_fetch_pc_unit.sv
// tb_fetch_pc_unit
//
// Directed bench for fetch_pc_unit. Two instances share all inputs: one with
// the MIPS delay slot (DELAY_SLOT=1) and one that squashes (DELAY_SLOT=0), so
// pc/pending/error behaviour is compared on both while flush_d and fetch_valid
// differences are checked side by side.

module tb_fetch_pc_unit;

  localparam logic [31:0] RST_PC = 32'h0040_0000;

  logic        clock;
  logic        reset_n;
  logic        stall_f;
  logic        pc_src;
  logic [31:0] jump_address;

  logic [31:0] pc_a, ppf_a, err_addr_a;
  logic        fv_a, fl_a, pend_a, err_a;
  logic [31:0] pc_b, ppf_b, err_addr_b;
  logic        fv_b, fl_b, pend_b, err_b;

  int pass_count;
  int check_count;

  fetch_pc_unit #(.RESET_PC(RST_PC), .DELAY_SLOT(1)) dut_slot (
    .clock(clock), .reset_n(reset_n), .stall_f(stall_f), .pc_src(pc_src),
    .jump_address(jump_address), .pc(pc_a), .pc_plus_four(ppf_a),
    .fetch_valid(fv_a), .flush_d(fl_a), .redirect_pending(pend_a),
    .addr_error(err_a), .error_address(err_addr_a)
  );

  fetch_pc_unit #(.RESET_PC(RST_PC), .DELAY_SLOT(0)) dut_squash (
    .clock(clock), .reset_n(reset_n), .stall_f(stall_f), .pc_src(pc_src),
    .jump_address(jump_address), .pc(pc_b), .pc_plus_four(ppf_b),
    .fetch_valid(fv_b), .flush_d(fl_b), .redirect_pending(pend_b),
    .addr_error(err_b), .error_address(err_addr_b)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Advance one rising edge and settle just after it.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Pulse reset low mid-cycle and release it mid-cycle after one edge.
  task automatic do_reset();
    #2 reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    stall_f = 1'b0; pc_src = 1'b0; jump_address = 32'd0;
    #2 reset_n = 1'b0;
    #1;
    check_count++; if (pc_a !== RST_PC) $display("[TB] FAIL reset_pc got %h want %h", pc_a, RST_PC); else pass_count++;
    check_count++; if (pc_b !== RST_PC) $display("[TB] FAIL reset_pc_b got %h want %h", pc_b, RST_PC); else pass_count++;
    check_count++; if (ppf_a !== 32'h0040_0004) $display("[TB] FAIL reset_ppf got %h want %h", ppf_a, 32'h0040_0004); else pass_count++;
    check_count++; if ({fv_a, fl_a, pend_a, err_a} !== 4'b1000) $display("[TB] FAIL reset_flags got %b want %b", {fv_a, fl_a, pend_a, err_a}, 4'b1000); else pass_count++;
    check_count++; if ({fv_b, fl_b, pend_b, err_b} !== 4'b1000) $display("[TB] FAIL reset_flags_b got %b want %b", {fv_b, fl_b, pend_b, err_b}, 4'b1000); else pass_count++;
    check_count++; if (err_addr_a !== 32'd0) $display("[TB] FAIL reset_err_addr got %h want %h", err_addr_a, 32'd0); else pass_count++;
    step();
    reset_n = 1'b1;
    #1;
    check_count++; if (pc_a !== RST_PC) $display("[TB] FAIL reset_hold got %h want %h", pc_a, RST_PC); else pass_count++;
    for (int i = 1; i <= 3; i++) begin
      step();
      check_count++; if (pc_a !== RST_PC + 32'(4 * i)) $display("[TB] FAIL seq_pc%0d got %h want %h", i, pc_a, RST_PC + 32'(4 * i)); else pass_count++;
      check_count++; if ({fv_a, pend_a} !== 2'b10) $display("[TB] FAIL seq_flags%0d got %b want %b", i, {fv_a, pend_a}, 2'b10); else pass_count++;
    end
  endtask

  task automatic test_live_redirect();
    do_reset();
    step();
    step();
    check_count++; if (pc_a !== 32'h0040_0008) $display("[TB] FAIL lr_start got %h want %h", pc_a, 32'h0040_0008); else pass_count++;
    pc_src = 1'b1; jump_address = 32'h0040_0100;
    #1;
    check_count++; if ({fv_a, fl_a} !== 2'b10) $display("[TB] FAIL lr_slot_fv_fl got %b want %b", {fv_a, fl_a}, 2'b10); else pass_count++;
    check_count++; if ({fv_b, fl_b} !== 2'b01) $display("[TB] FAIL lr_squash_fv_fl got %b want %b", {fv_b, fl_b}, 2'b01); else pass_count++;
    step();
    pc_src = 1'b0;
    #1;
    check_count++; if (pc_a !== 32'h0040_0100) $display("[TB] FAIL lr_pc got %h want %h", pc_a, 32'h0040_0100); else pass_count++;
    check_count++; if (pc_b !== 32'h0040_0100) $display("[TB] FAIL lr_pc_b got %h want %h", pc_b, 32'h0040_0100); else pass_count++;
    check_count++; if ({fv_b, fl_b} !== 2'b10) $display("[TB] FAIL lr_after_squash got %b want %b", {fv_b, fl_b}, 2'b10); else pass_count++;
  endtask

  task automatic test_stalled_redirect();
    stall_f = 1'b1; pc_src = 1'b1; jump_address = 32'h0040_0200;
    #1;
    check_count++; if ({fv_a, fv_b, fl_b} !== 3'b000) $display("[TB] FAIL st_fetch got %b want %b", {fv_a, fv_b, fl_b}, 3'b000); else pass_count++;
    step();
    check_count++; if (pc_a !== 32'h0040_0100) $display("[TB] FAIL st_pc1 got %h want %h", pc_a, 32'h0040_0100); else pass_count++;
    check_count++; if (pend_a !== 1'b1) $display("[TB] FAIL st_pend1 got %b want %b", pend_a, 1'b1); else pass_count++;
    jump_address = 32'h0040_0300;
    step();
    pc_src = 1'b0;
    step();
    check_count++; if (pc_a !== 32'h0040_0100) $display("[TB] FAIL st_pc3 got %h want %h", pc_a, 32'h0040_0100); else pass_count++;
    check_count++; if ({pend_a, pend_b} !== 2'b11) $display("[TB] FAIL st_pend3 got %b want %b", {pend_a, pend_b}, 2'b11); else pass_count++;
    stall_f = 1'b0;
    #1;
    check_count++; if ({fv_a, fl_a, fv_b, fl_b} !== 4'b1001) $display("[TB] FAIL st_release got %b want %b", {fv_a, fl_a, fv_b, fl_b}, 4'b1001); else pass_count++;
    step();
    check_count++; if (pc_a !== 32'h0040_0300) $display("[TB] FAIL st_pc_out got %h want %h", pc_a, 32'h0040_0300); else pass_count++;
    check_count++; if (pend_a !== 1'b0) $display("[TB] FAIL st_pend_clr got %b want %b", pend_a, 1'b0); else pass_count++;
  endtask

  task automatic test_live_beats_pending();
    stall_f = 1'b1; pc_src = 1'b1; jump_address = 32'h0040_0300;
    step();
    check_count++; if (pend_a !== 1'b1) $display("[TB] FAIL lbp_pend got %b want %b", pend_a, 1'b1); else pass_count++;
    stall_f = 1'b0; jump_address = 32'h0040_0500;
    step();
    pc_src = 1'b0;
    check_count++; if (pc_a !== 32'h0040_0500) $display("[TB] FAIL lbp_pc got %h want %h", pc_a, 32'h0040_0500); else pass_count++;
    check_count++; if (pend_a !== 1'b0) $display("[TB] FAIL lbp_pend_clr got %b want %b", pend_a, 1'b0); else pass_count++;
    step();
    check_count++; if (pc_a !== 32'h0040_0504) $display("[TB] FAIL lbp_next got %h want %h", pc_a, 32'h0040_0504); else pass_count++;
  endtask

  task automatic test_misaligned();
    pc_src = 1'b1; jump_address = 32'h0040_0102;
    step();
    pc_src = 1'b0;
    check_count++; if (pc_a !== 32'h0040_0100) $display("[TB] FAIL mis_pc got %h want %h", pc_a, 32'h0040_0100); else pass_count++;
    check_count++; if (err_a !== 1'b1) $display("[TB] FAIL mis_err got %b want %b", err_a, 1'b1); else pass_count++;
    check_count++; if (err_addr_a !== 32'h0040_0102) $display("[TB] FAIL mis_eaddr got %h want %h", err_addr_a, 32'h0040_0102); else pass_count++;
    step();
    check_count++; if (err_a !== 1'b0) $display("[TB] FAIL mis_err_pulse got %b want %b", err_a, 1'b0); else pass_count++;
    check_count++; if (err_addr_b !== 32'h0040_0102) $display("[TB] FAIL mis_eaddr_hold got %h want %h", err_addr_b, 32'h0040_0102); else pass_count++;
    // Misaligned redirect captured into the pending register while stalled.
    stall_f = 1'b1; pc_src = 1'b1; jump_address = 32'h0040_0207;
    step();
    stall_f = 1'b0; pc_src = 1'b0;
    check_count++; if ({err_a, pend_a} !== 2'b11) $display("[TB] FAIL mis_pend_err got %b want %b", {err_a, pend_a}, 2'b11); else pass_count++;
    check_count++; if (err_addr_a !== 32'h0040_0207) $display("[TB] FAIL mis_pend_eaddr got %h want %h", err_addr_a, 32'h0040_0207); else pass_count++;
    step();
    check_count++; if (pc_a !== 32'h0040_0204) $display("[TB] FAIL mis_pend_pc got %h want %h", pc_a, 32'h0040_0204); else pass_count++;
    check_count++; if (err_a !== 1'b0) $display("[TB] FAIL mis_pend_pulse got %b want %b", err_a, 1'b0); else pass_count++;
  endtask

  task automatic test_back_to_back();
    pc_src = 1'b1; jump_address = 32'h0040_0010;
    step();
    check_count++; if (pc_a !== 32'h0040_0010) $display("[TB] FAIL b2b_pc1 got %h want %h", pc_a, 32'h0040_0010); else pass_count++;
    jump_address = 32'h0040_0020;
    step();
    pc_src = 1'b0;
    check_count++; if (pc_b !== 32'h0040_0020) $display("[TB] FAIL b2b_pc2 got %h want %h", pc_b, 32'h0040_0020); else pass_count++;
  endtask

  task automatic test_wrap_and_async_reset();
    pc_src = 1'b1; jump_address = 32'hFFFF_FFFC;
    step();
    pc_src = 1'b0;
    #1;
    check_count++; if (ppf_a !== 32'h0000_0000) $display("[TB] FAIL wrap_ppf got %h want %h", ppf_a, 32'h0000_0000); else pass_count++;
    step();
    check_count++; if (pc_a !== 32'h0000_0000) $display("[TB] FAIL wrap_pc got %h want %h", pc_a, 32'h0000_0000); else pass_count++;
    check_count++; if (err_a !== 1'b0) $display("[TB] FAIL wrap_err got %b want %b", err_a, 1'b0); else pass_count++;
    stall_f = 1'b1; pc_src = 1'b1; jump_address = 32'h0040_0600;
    step();
    check_count++; if (pend_a !== 1'b1) $display("[TB] FAIL ar_pend_set got %b want %b", pend_a, 1'b1); else pass_count++;
    #2 reset_n = 1'b0;
    #1;
    check_count++; if (pc_a !== RST_PC) $display("[TB] FAIL ar_pc got %h want %h", pc_a, RST_PC); else pass_count++;
    check_count++; if ({pend_a, pend_b} !== 2'b00) $display("[TB] FAIL ar_pend got %b want %b", {pend_a, pend_b}, 2'b00); else pass_count++;
    check_count++; if (err_addr_a !== 32'd0) $display("[TB] FAIL ar_eaddr got %h want %h", err_addr_a, 32'd0); else pass_count++;
    stall_f = 1'b0; pc_src = 1'b0;
    step();
    reset_n = 1'b1;
  endtask

  initial begin
    pass_count = 0;
    check_count = 0;
    reset_n = 1'b1;
    test_reset();
    test_live_redirect();
    test_stalled_redirect();
    test_live_beats_pending();
    test_misaligned();
    test_back_to_back();
    test_wrap_and_async_reset();
    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
